// File: rtl/pce_vdc_pkg.sv
// Shared types and default geometry for the HuC6270 pixel path.
package pce_vdc_pkg;

  localparam int unsigned PLANES_DEF       = 4;
  localparam int unsigned PIX_PER_WORD_DEF = 8;

  typedef logic [PLANES_DEF-1:0] pix_idx_t;
  typedef logic [3:0]            palette_t;

endpackage

// File: rtl/plane_bit_reverse.sv
// Conditional per-plane bit reversal, applied to planar words as they are accepted.
module plane_bit_reverse
  import pce_vdc_pkg::*;
#(
  parameter int unsigned PLANES       = PLANES_DEF,
  parameter int unsigned PIX_PER_WORD = PIX_PER_WORD_DEF
) (
  input  logic                                     flip_i,
  input  logic [PLANES-1:0][PIX_PER_WORD-1:0]      planes_i,
  output logic [PLANES-1:0][PIX_PER_WORD-1:0]      planes_o
);

  always_comb begin
    planes_o = '0;
    for (int unsigned p = 0; p < PLANES; p++) begin
      for (int unsigned b = 0; b < PIX_PER_WORD; b++) begin
        planes_o[p][b] = flip_i ? planes_i[p][PIX_PER_WORD-1-b] : planes_i[p][b];
      end
    end
  end

endmodule

// File: rtl/planar_pixel_shifter.sv
// Double-buffered planar-to-index serialiser: holding word plus active shift register,
// one packed palette index per pix_en.
module planar_pixel_shifter
  import pce_vdc_pkg::*;
#(
  parameter int unsigned PLANES       = PLANES_DEF,
  parameter int unsigned PIX_PER_WORD = PIX_PER_WORD_DEF
) (
  input  logic                                clock,
  input  logic                                reset_N,
  input  logic                                flush,
  input  logic                                pix_en,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [PLANES-1:0][PIX_PER_WORD-1:0] in_planes,
  input  logic                                in_hflip,
  input  logic [3:0]                          in_palette,
  output logic                                out_valid,
  output logic [PLANES-1:0]                   out_index,
  output logic [3:0]                          out_palette,
  output logic                                out_last,
  output logic                                underrun
);

  localparam int unsigned    CW       = $clog2(PIX_PER_WORD);
  localparam logic [CW-1:0]  CNT_LAST = CW'(PIX_PER_WORD - 1);

  typedef logic [PLANES-1:0][PIX_PER_WORD-1:0] planes_t;

  planes_t       in_flipped;
  planes_t       hold_q, hold_d, act_q, act_d;
  palette_t      hold_pal_q, hold_pal_d, act_pal_q, act_pal_d;
  logic          hold_full_q, hold_full_d, act_full_q, act_full_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          underrun_q, underrun_d;
  logic          accept, last_px, xfer;

  plane_bit_reverse #(
    .PLANES       (PLANES),
    .PIX_PER_WORD (PIX_PER_WORD)
  ) u_flip (
    .flip_i   (in_hflip),
    .planes_i (in_planes),
    .planes_o (in_flipped)
  );

  assign in_ready = !hold_full_q && !flush;
  assign accept   = in_valid && in_ready;
  assign last_px  = act_full_q && (cnt_q == CNT_LAST);
  // Refill on the last pixel's enable keeps consecutive words gap-free.
  assign xfer     = hold_full_q && (!act_full_q || (pix_en && last_px));

  always_comb begin
    hold_d      = hold_q;
    hold_pal_d  = hold_pal_q;
    hold_full_d = hold_full_q;
    act_d       = act_q;
    act_pal_d   = act_pal_q;
    act_full_d  = act_full_q;
    cnt_d       = cnt_q;
    underrun_d  = 1'b0;
    if (flush) begin
      hold_full_d = 1'b0;
      act_full_d  = 1'b0;
      cnt_d       = '0;
    end else begin
      underrun_d = pix_en && !act_full_q;
      if (xfer) begin
        act_d       = hold_q;
        act_pal_d   = hold_pal_q;
        act_full_d  = 1'b1;
        cnt_d       = '0;
        hold_full_d = 1'b0;
      end else if (pix_en && act_full_q) begin
        for (int unsigned p = 0; p < PLANES; p++) begin
          act_d[p] = {act_q[p][PIX_PER_WORD-2:0], 1'b0};
        end
        if (last_px) begin
          act_full_d = 1'b0;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      if (accept) begin
        hold_d      = in_flipped;
        hold_pal_d  = in_palette;
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      hold_q      <= '0;
      hold_pal_q  <= '0;
      hold_full_q <= 1'b0;
      act_q       <= '0;
      act_pal_q   <= '0;
      act_full_q  <= 1'b0;
      cnt_q       <= '0;
      underrun_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_pal_q  <= hold_pal_d;
      hold_full_q <= hold_full_d;
      act_q       <= act_d;
      act_pal_q   <= act_pal_d;
      act_full_q  <= act_full_d;
      cnt_q       <= cnt_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    out_index = '0;
    for (int unsigned p = 0; p < PLANES; p++) begin
      out_index[p] = act_full_q && act_q[p][PIX_PER_WORD-1];
    end
  end

  assign out_valid   = act_full_q;
  assign out_palette = act_pal_q;
  assign out_last    = last_px;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_planar_pixel_shifter.sv
// Scoreboard bench for planar_pixel_shifter: expected pixels queued on accept, popped on consume.
module tb_planar_pixel_shifter;

  localparam int unsigned PL = 4;
  localparam int unsigned PX = 8;

  typedef logic [PL-1:0][PX-1:0] planes_t;
  typedef struct packed {
    logic [PL-1:0] idx;
    logic [3:0]    pal;
    logic          last;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_N, flush, pix_en, in_valid, in_ready, in_hflip;
  planes_t       in_planes;
  logic [3:0]    in_palette, out_palette;
  logic          out_valid, out_last, underrun;
  logic [PL-1:0] out_index;

  exp_t          q[$];
  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  int unsigned   ur_cnt   = 0;

  logic          prev_rst = 1'b0;
  logic          prev_pen, prev_valid, prev_flush;
  logic [PL-1:0] prev_idx;

  planar_pixel_shifter #(
    .PLANES       (PL),
    .PIX_PER_WORD (PX)
  ) dut (
    .clock       (clock),
    .reset_N     (reset_N),
    .flush       (flush),
    .pix_en      (pix_en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_planes   (in_planes),
    .in_hflip    (in_hflip),
    .in_palette  (in_palette),
    .out_valid   (out_valid),
    .out_index   (out_index),
    .out_palette (out_palette),
    .out_last    (out_last),
    .underrun    (underrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel i of a word, leftmost first; flip reads the plane from bit 0 upward.
  function automatic logic [PL-1:0] exp_px(input planes_t w, input logic f, input int unsigned i);
    logic [PL-1:0] r;
    r = '0;
    for (int unsigned p = 0; p < PL; p++) begin
      r[p] = f ? w[p][i] : w[p][PX-1-i];
    end
    return r;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    #2;
    if (!reset_N) begin
      q.delete();
      prev_rst = 1'b0;
    end else begin
      if (prev_rst) begin
        check("underrun", {31'd0, underrun}, {31'd0, prev_pen && !prev_valid && !prev_flush});
        if (!prev_pen && !prev_flush && prev_valid) begin
          check("frozen_valid", {31'd0, out_valid}, 32'd1);
          check("frozen_idx", {28'd0, out_index}, {28'd0, prev_idx});
        end
      end
      if (underrun) ur_cnt++;
      if (!out_valid) begin
        check("idle_idx", {28'd0, out_index}, 32'd0);
        check("idle_last", {31'd0, out_last}, 32'd0);
      end
      if (out_valid && pix_en) begin
        if (q.size() == 0) begin
          check("unexpected_pixel", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("pix_idx", {28'd0, out_index}, {28'd0, e.idx});
          check("pix_pal", {28'd0, out_palette}, {28'd0, e.pal});
          check("pix_last", {31'd0, out_last}, {31'd0, e.last});
        end
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && in_ready) begin
        for (int unsigned i = 0; i < PX; i++) begin
          e.idx  = exp_px(in_planes, in_hflip, i);
          e.pal  = in_palette;
          e.last = (i == PX - 1);
          q.push_back(e);
        end
      end
      prev_pen   = pix_en;
      prev_valid = out_valid;
      prev_flush = flush;
      prev_idx   = out_index;
      prev_rst   = 1'b1;
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input planes_t w, input logic f, input logic [3:0] pal);
    int unsigned n = 0;
    in_planes  = w;
    in_hflip   = f;
    in_palette = pal;
    in_valid   = 1'b1;
    #3;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      #3;
      n++;
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Called at a falling edge; pix_en every period cycles until the scoreboard empties.
  task automatic drain(input int unsigned period, output int unsigned cycles);
    int unsigned n = 0;
    forever begin
      pix_en = ((n % period) == 0);
      #3;
      if (q.size() == 0 || n >= 400) break;
      @(negedge clock);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 32'd0);
    cycles = n + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    planes_t     w0, w1, w2;
    int unsigned n, ur0;
    w0 = {8'hF0, 8'hCC, 8'hAA, 8'h00};
    w1 = {8'h3C, 8'h96, 8'h5A, 8'hE1};
    w2 = {8'h81, 8'h42, 8'h24, 8'h18};

    reset_N = 1'b0; flush = 1'b0; pix_en = 1'b0; in_valid = 1'b0;
    in_hflip = 1'b0; in_planes = '0; in_palette = '0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_idx", {28'd0, out_index}, 32'd0);
    check("rst_pal", {28'd0, out_palette}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock); @(negedge clock);
    reset_N = 1'b1;
    @(negedge clock);

    // Basic extraction with latency, then starvation.
    pix_en = 1'b1;
    send(w0, 1'b0, 4'h3);
    #3;
    check("lat_hold", {31'd0, out_valid}, 32'd0);
    @(negedge clock); #3;
    check("lat_first", {31'd0, out_valid}, 32'd1);
    @(negedge clock);
    drain(1, n);
    check("basic_cycles", n, 32'd7);
    ur0 = ur_cnt;
    repeat (5) begin @(negedge clock); #3; end
    check("starve_ur", ur_cnt - ur0, 32'd4);
    check("starve_valid", {31'd0, out_valid}, 32'd0);
    check("starve_idx", {28'd0, out_index}, 32'd0);

    // Horizontal flip.
    @(negedge clock);
    send(w0, 1'b1, 4'hA);
    drain(1, n);
    check("flip_cycles", n, 32'd9);

    // Back-to-back words, no bubble.
    @(negedge clock);
    pix_en = 1'b0;
    send(w1, 1'b0, 4'h3);
    send(w2, 1'b1, 4'h5);
    #3;
    check("b2b_ready", {31'd0, in_ready}, 32'd0);
    check("b2b_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clock);
    drain(1, n);
    check("b2b_cycles", n, 32'd16);

    // Sparse pixel enable.
    @(negedge clock);
    pix_en = 1'b0;
    send(w0, 1'b0, 4'h6);
    @(negedge clock);
    ur0 = ur_cnt;
    drain(3, n);
    check("sparse_cycles", n, 32'd22);
    check("sparse_ur", ur_cnt - ur0, 32'd0);

    // Flush mid-word with hold full.
    @(negedge clock);
    pix_en = 1'b0;
    send(w1, 1'b0, 4'h9);
    send(w2, 1'b0, 4'h7);
    repeat (4) begin pix_en = 1'b1; @(negedge clock); end
    flush = 1'b1; pix_en = 1'b1;
    in_planes = w0; in_palette = 4'hE; in_valid = 1'b1;
    #3;
    check("flush_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clock); #3;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_ur0", {31'd0, underrun}, 32'd0);
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0; pix_en = 1'b0;
    #3;
    check("post_flush_valid", {31'd0, out_valid}, 32'd0);
    check("post_flush_ready", {31'd0, in_ready}, 32'd1);
    check("post_flush_ur", {31'd0, underrun}, 32'd0);
    @(negedge clock); #3;
    check("flush_drop", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-word, then resume.
    @(negedge clock);
    send(w1, 1'b0, 4'hC);
    @(negedge clock);
    pix_en = 1'b1;
    @(negedge clock); @(negedge clock);
    #1;
    reset_N = 1'b0;
    #1;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_idx", {28'd0, out_index}, 32'd0);
    check("mrst_pal", {28'd0, out_palette}, 32'd0);
    check("mrst_last", {31'd0, out_last}, 32'd0);
    check("mrst_underrun", {31'd0, underrun}, 32'd0);
    check("mrst_ready", {31'd0, in_ready}, 32'd1);
    pix_en = 1'b0;
    @(negedge clock);
    reset_N = 1'b1;
    @(negedge clock);
    pix_en = 1'b1;
    send(w2, 1'b1, 4'h2);
    drain(1, n);
    check("resume_cycles", n, 32'd9);

    @(negedge clock);
    pix_en = 1'b0;
    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
